// File: rtl/mdu_sequencer.sv
// mdu_sequencer: multi-cycle multiply/divide sequencer for the E stage.
//
// Accepts a single-cycle start pulse with an op and two forwarded operands,
// runs a latency countdown and then commits the result into the
// architectural HI/LO registers. mthi/mtlo write HI/LO directly in one cycle.
//
// Ports:
//   clk      in   pipeline clock, rising edge
//   reset    in   asynchronous active-low reset
//   start    in   E-stage MDU op valid (one-cycle pulse)
//   mdu_op   in   0=mult 1=multu 2=div 3=divu 4=mthi 5=mtlo 6/7=no-op
//   a, b     in   rs / rt operands
//   d_is_md  in   instruction in D is an MDU-class instruction
//   busy     out  operation in flight
//   stall_md out  stall request to the hazard unit
//   hi, lo   out  architectural HI / LO
//   cancel   in   (only with MDU_CANCEL_EN) flush: abort in-flight op and
//                 block a same-cycle start
//
// Optional feature macro: MDU_CANCEL_EN.

module mdu_sequencer #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdu_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
`ifdef MDU_CANCEL_EN
  input  logic        cancel,
`endif
  input  logic        d_is_md,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e      state_q, state_d;
  logic [3:0]  count_q, count_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        cancel_w;

`ifdef MDU_CANCEL_EN
  assign cancel_w = cancel;
`else
  assign cancel_w = 1'b0;
`endif

  // op_q[0] set means the unsigned variant, op_q[1] set means divide.
  logic        signed_op;
  logic [63:0] a_ext, b_ext, prod;
  logic        a_neg, b_neg;
  logic [31:0] dvd, dvs, dvs_safe, uquot, urem, quot, rem;

  assign signed_op = ~op_q[0];
  // Sign-extending to 64 bits makes the low 64 bits of the product correct
  // for both signed and unsigned multiplies.
  assign a_ext = signed_op ? {{32{a_q[31]}}, a_q} : {32'b0, a_q};
  assign b_ext = signed_op ? {{32{b_q[31]}}, b_q} : {32'b0, b_q};
  assign prod  = a_ext * b_ext;

  // Signed divide on magnitudes; 0x80000000 / -1 wraps to 0x80000000 rem 0.
  assign a_neg    = signed_op & a_q[31];
  assign b_neg    = signed_op & b_q[31];
  assign dvd      = a_neg ? -a_q : a_q;
  assign dvs      = b_neg ? -b_q : b_q;
  assign dvs_safe = (dvs == 32'd0) ? 32'd1 : dvs;
  assign uquot    = dvd / dvs_safe;
  assign urem     = dvd % dvs_safe;
  assign quot     = (a_neg ^ b_neg) ? -uquot : uquot;
  assign rem      = a_neg ? -urem : urem;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      StIdle: begin
        if (start && !cancel_w) begin
          case (mdu_op)
            3'd0, 3'd1, 3'd2, 3'd3: begin
              op_d    = mdu_op[1:0];
              a_d     = a;
              b_d     = b;
              count_d = mdu_op[1] ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
              state_d = StRun;
            end
            3'd4:    hi_d = a;
            3'd5:    lo_d = a;
            default: ;
          endcase
        end
      end
      StRun: begin
        if (cancel_w) begin
          state_d = StIdle;
          count_d = 4'd0;
        end else begin
          count_d = count_q - 4'd1;
          if (count_q == 4'd1) begin
            state_d = StIdle;
            if (!op_q[1]) begin
              hi_d = prod[63:32];
              lo_d = prod[31:0];
            end else if (b_q != 32'd0) begin
              // Divide by zero leaves HI/LO untouched.
              hi_d = rem;
              lo_d = quot;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      count_q <= 4'd0;
      op_q    <= 2'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy     = (state_q == StRun);
  // Covers the start cycle before busy rises as well as the RUN window.
  assign stall_md = d_is_md & (start | busy);
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
module tb_mdu_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  mdu_op = 3'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        d_is_md = 1'b0;
`ifdef MDU_CANCEL_EN
  logic        cancel = 1'b0;
`endif
  logic        busy, stall_md;
  logic [31:0] hi, lo;

  mdu_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .mdu_op   (mdu_op),
    .a        (a),
    .b        (b),
`ifdef MDU_CANCEL_EN
    .cancel   (cancel),
`endif
    .d_is_md  (d_is_md),
    .busy     (busy),
    .stall_md (stall_md),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  bit   skip_fall = 1'b0;
  bit   prev_busy = 1'b0;
  int   busy_cnt = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops an expected result whenever busy falls.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      prev_busy = 1'b0;
      busy_cnt  = 0;
    end else begin
      if (start && busy) begin
        checks++;
        errors++;
        $display("FAIL start_in_run: got start=1 busy=1 expected no start while busy");
      end
      if (prev_busy && !busy) begin
        if (skip_fall) begin
          skip_fall = 1'b0;
        end else if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got completion expected none");
        end else begin
          e = sb.pop_front();
          check32("sb_hi", hi, e.hi);
          check32("sb_lo", lo, e.lo);
          check32("sb_latency", 32'(busy_cnt), 32'(e.lat));
        end
        busy_cnt = 0;
      end
      if (busy) busy_cnt++;
      prev_busy = busy;
    end
  end

  task automatic start_op(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv);
    @(posedge clk);
    #1;
    start  = 1'b1;
    mdu_op = op;
    a      = av;
    b      = bv;
    @(posedge clk);
    #1;
    start  = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clk);
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    check32(name, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    // Reset held for 3 cycles, then 5 idle cycles.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check32("rst_busy", {31'b0, busy}, 32'd0);
      check32("rst_stall", {31'b0, stall_md}, 32'd0);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check32("idle_busy", {31'b0, busy}, 32'd0);
      check32("idle_stall", {31'b0, stall_md}, 32'd0);
    end
    check32("rst_hi", hi, 32'd0);
    check32("rst_lo", lo, 32'd0);

    // mult -2 * 3 = -6
    sb.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFA, 5});
    start_op(3'd0, 32'hFFFF_FFFE, 32'd3);
    wait_idle("mult_done");

    // divu 100/7, then div -7/2
    sb.push_back('{32'd2, 32'd14, 10});
    start_op(3'd3, 32'd100, 32'd7);
    wait_idle("divu_done");
    sb.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFD, 10});
    start_op(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait_idle("div_done");

    // Stall with d_is_md held: 0x10000 * 0x10000 = 2^32
    d_is_md = 1'b1;
    sb.push_back('{32'd1, 32'd0, 5});
    @(posedge clk);
    #1;
    start = 1'b1; mdu_op = 3'd0; a = 32'h0001_0000; b = 32'h0001_0000;
    @(negedge clk);
    check32("stall_start", {31'b0, stall_md}, 32'd1);
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      check32("stall_run", {31'b0, stall_md}, 32'd1);
    end
    @(negedge clk);
    check32("stall_drop", {31'b0, stall_md}, 32'd0);
    d_is_md = 1'b0;

    // No stall when D holds no MDU op: multu 0xFFFFFFFF^2
    sb.push_back('{32'hFFFF_FFFE, 32'h0000_0001, 5});
    @(posedge clk);
    #1;
    start = 1'b1; mdu_op = 3'd1; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
    @(negedge clk);
    check32("nostall_start", {31'b0, stall_md}, 32'd0);
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check32("nostall_run", {31'b0, stall_md}, 32'd0);
    end

    // mthi then mtlo on consecutive cycles
    @(posedge clk);
    #1;
    start = 1'b1; mdu_op = 3'd4; a = 32'h1234_5678; b = 32'd0;
    @(posedge clk);
    #1;
    mdu_op = 3'd5; a = 32'h9ABC_DEF0;
    @(negedge clk);
    check32("mthi_hi", hi, 32'h1234_5678);
    check32("mthi_busy", {31'b0, busy}, 32'd0);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check32("mtlo_lo", lo, 32'h9ABC_DEF0);
    check32("mtlo_hi", hi, 32'h1234_5678);
    check32("mtlo_busy", {31'b0, busy}, 32'd0);

    // div by zero: full latency, HI/LO unchanged
    sb.push_back('{32'h1234_5678, 32'h9ABC_DEF0, 10});
    start_op(3'd2, 32'd5, 32'd0);
    wait_idle("div0_done");

    // Signed overflow case
    sb.push_back('{32'd0, 32'h8000_0000, 10});
    start_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle("divovf_done");

    // Back-to-back: second start in the first IDLE cycle
    sb.push_back('{32'd0, 32'd63, 5});
    sb.push_back('{32'd7, 32'd7, 10});
    start_op(3'd0, 32'd7, 32'd9);
    repeat (4) @(posedge clk);
    start_op(3'd3, 32'd63, 32'd8);
    wait_idle("b2b_done");

    // Reset in RUN cycle 3 of a div: result discarded
    start_op(3'd2, 32'd1000, 32'd3);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check32("rstmid_busy", {31'b0, busy}, 32'd0);
    check32("rstmid_hi", hi, 32'd0);
    check32("rstmid_lo", lo, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (15) @(negedge clk);
    check32("rstpost_busy", {31'b0, busy}, 32'd0);
    check32("rstpost_hi", hi, 32'd0);
    check32("rstpost_lo", lo, 32'd0);

`ifdef MDU_CANCEL_EN
    // Cancel at busy cycle 4 of mult 5*6
    start_op(3'd0, 32'd5, 32'd6);
    repeat (3) @(posedge clk);
    #1;
    cancel    = 1'b1;
    skip_fall = 1'b1;
    @(posedge clk);
    #1 cancel = 1'b0;
    @(negedge clk);
    check32("cancel_busy", {31'b0, busy}, 32'd0);
    check32("cancel_hi", hi, 32'd0);
    check32("cancel_lo", lo, 32'd0);
    sb.push_back('{32'd0, 32'd30, 5});
    start_op(3'd0, 32'd5, 32'd6);
    wait_idle("cancel_redo_done");
`endif

    repeat (2) @(negedge clk);
    check32("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
- Multi-cycle multiply/divide sequencer for the E stage of the 5-stage MIPS pipeline.
- Accepts a start pulse with an op and two operands, then runs a latency countdown.
- Commits results into architectural HI/LO registers and presents them for mfhi/mflo.
- Drives busy and a stall request to the hazard unit so that MDU-class instructions in D wait while an operation is in flight.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15).
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15).

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  E-stage MDU op valid this cycle (single-cycle pulse per instruction).
- mdu_op  in  3  0=mult 1=multu 2=div 3=divu 4=mthi 5=mtlo; 6 and 7 are no-op.
- a  in  32  rs operand, already forwarded.
- b  in  32  rt operand, already forwarded.
- d_is_md  in  1  instruction in D is mult/div/mthi/mtlo/mfhi/mflo.
- busy  out  1  operation in flight.
- stall_md  out  1  stall request to hazard unit.
- hi  out  32  architectural HI.
- lo  out  32  architectural LO.

Behaviour:
- Reset: reset low clears, asynchronously, state=IDLE, count=0, hi=0, lo=0, busy=0, latched operands=0. This holds regardless of state, including mid-operation; the in-flight result is discarded.
- FSM has 2 states, IDLE and RUN. busy=1 exactly in RUN.
- IDLE + start + op in 0..3 (mult/multu/div/divu):
  - Latch op, a and b.
  - Load count with MULT_CYCLES (op 0/1) or DIV_CYCLES (op 2/3).
  - Go to RUN.
- IDLE + start + op 4 (mthi): hi<=a at the edge. No busy; state stays IDLE.
- IDLE + start + op 5 (mtlo): lo<=a at the edge. No busy; state stays IDLE.
- IDLE + start + op 6/7: no effect.
- RUN:
  - count decrements each edge.
  - On the edge where count==1: commit the result to hi/lo and go to IDLE.
  - Timing: with start in cycle t and latency N, busy is high in cycles t+1..t+N, new hi/lo is visible and busy=0 from cycle t+N+1.
- start while in RUN: ignored entirely (the hazard unit guarantees it never happens; the bench flags it as an error).
- stall_md = d_is_md & (start | busy). This is combinational. It covers the start cycle before busy rises and the full RUN window. It drops in cycle t+N+1.
- hi/lo outputs are registers with no bypass: mfhi/mflo read the committed value only.
- Arithmetic, computed from the latched operands:
  - mult: {hi,lo} = signed a × signed b, 64-bit.
  - multu: {hi,lo} = unsigned 64-bit product.
  - div: lo = quotient truncated toward zero; hi = remainder, sign of dividend.
  - divu: unsigned quotient/remainder.
- Boundary cases:
  - b==0 for div/divu: the op runs the full DIV_CYCLES but hi/lo are left unchanged.
  - div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Back-to-back: start may be asserted in cycle t+N+1 (the first IDLE cycle). It is accepted normally.

Optional Feature:
- Macro: MDU_CANCEL_EN.
- Defined:
  - Adds input port cancel (1 bit).
  - cancel=1 in any cycle forces IDLE at the next edge with no hi/lo write, and blocks an op that has start in the same cycle, including mthi/mtlo.
  - cancel has priority over the commit edge.
  - Used for exception flush.
- Undefined: no cancel port; every accepted op runs to completion.

Test Plan:
- Reset: hold reset=0 for 3 cycles, release, 5 idle cycles -> hi=0, lo=0, busy=0, stall_md=0 throughout.
- mult: start, op=0, a=0xFFFFFFFE (-2), b=3 -> busy high for exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA; busy=0 in cycle t+6.
- divu then div:
  - divu a=100, b=7 -> after 10 busy cycles lo=14, hi=2.
  - Then div a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- Stall:
  - d_is_md=1 held from cycle t (start cycle) of a mult -> stall_md=1 in cycles t..t+5, 0 in t+6.
  - d_is_md=0 -> stall_md=0 throughout.
- mthi/mtlo and div by zero:
  - mthi a=0x12345678, then mtlo a=0x9ABCDEF0 -> hi/lo show those values one cycle later with no busy.
  - Then div b=0 -> 10 busy cycles, hi/lo unchanged.
- Reset mid-op: assert reset at RUN cycle 3 of a div -> busy=0, hi=lo=0 immediately (asynchronous); no commit after release.
- With MDU_CANCEL_EN: mult 5×6, cancel at busy cycle 4 -> busy=0 next cycle, hi/lo keep prior values (0,0); a new mult 5×6 afterwards gives lo=30, hi=0.
